// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared types and helpers for the data_ram block.
//   - state_t / SWEEP / READY : FSM encoding of the clear engine.
//   - DEF_DATA_W / DEF_ADDR_W : default geometry (8-bit words, 256 entries).
//   - NBYTES                  : byte lanes of a default-width word.
//   - clog2()                 : ceiling log2 for sizing the sweep pointer.
package data_ram_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int NBYTES     = DEF_DATA_W / 8;

    typedef logic [0:0] state_t;
    localparam state_t SWEEP = 1'b0;  // zeroing the array, not accepting requests
    localparam state_t READY = 1'b1;  // serving requests

    // Number of bits needed to index 'value' distinct items (0 for value <= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/data_ram_if.sv
// data_ram_if: request/response bundle between the memory stage and data_ram.
//   master (processor side) drives : req, we, addr, wdata, be, clr
//   slave  (data_ram)       drives : ready, rvalid, rdata, err
//
// Handshake: a request transfers on a rising edge where req & ready & ~clr.
// ready is a registered FSM output and never depends on req or clr in the
// same cycle. rvalid and err are single-cycle strobes answering the request
// accepted on the previous edge; there is no back-pressure on the response.
interface data_ram_if
    import data_ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   be;
    logic                  clr;
    logic                  ready;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;
    logic                  err;

    modport master (
        output req, we, addr, wdata, be, clr,
        input  ready, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata, be, clr,
        output ready, rvalid, rdata, err
    );
endinterface

// File: rtl/data_ram_ram_array.sv
// ram_array: DEPTH x DATA_W single-port storage.
//   clk_i    : clock
//   rst_i    : synchronous reset of the read register only (array not reset)
//   addr_i   : word address shared by the write and read port
//   we_i     : write strobe; be_i selects which byte lanes are written
//   wdata_i  : write data
//   re_i     : load the read register this edge
//   rzero_i  : with re_i, load zero instead of mem[addr_i] (out-of-range read)
//   rdata_o  : registered read data, held until the next re_i or reset
module ram_array #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic                re_i,
    input  logic                rzero_i,
    output logic [DATA_W-1:0]   rdata_o
);
    localparam int LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int i = 0; i < LANES; i++) begin
                if (be_i[i]) begin
                    mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rzero_i ? '0 : mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/data_ram.sv
// data_ram: parametrised single-port data memory with byte-lane writes,
// registered read, request/ready handshake and a hardware clear engine that
// zeroes one word per cycle after reset or a clr request.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   bus     : data_ram_if slave (req/we/addr/wdata/be/clr in, ready/rvalid/rdata/err out)
//   state_o : current FSM state (SWEEP/READY)
//   ptr_o   : current sweep pointer (0 while READY)
module data_ram
    import data_ram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    data_ram_if.slave         bus,
    output state_t            state_o,
    output logic [ADDR_W-1:0] ptr_o
);
    localparam int LANES = DATA_W / 8;
    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              rvalid_q, err_q;

    logic              in_range;
    logic              accept;
    logic              rd_acc;

    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [LANES-1:0]  arr_be;
    logic [DATA_W-1:0] arr_wdata;
    logic [DATA_W-1:0] arr_rdata;

    assign in_range = {1'b0, bus.addr} < DEPTH_L;
    // clr wins over a same-cycle request, which is simply dropped.
    assign accept   = bus.req & (state_q == READY) & ~bus.clr & ~rst;
    assign rd_acc   = accept & ~bus.we;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            SWEEP: begin
                if (ptr_q == LAST_PTR) begin
                    state_d = READY;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            READY: begin
                if (bus.clr) begin
                    state_d = SWEEP;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = SWEEP;
                ptr_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SWEEP;
            ptr_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            rvalid_q <= rd_acc;
            err_q    <= accept & ~in_range;
        end
    end

    // The sweep engine owns the single array port while clearing.
    always_comb begin
        if (state_q == SWEEP) begin
            arr_we    = ~rst;
            arr_addr  = ADDR_W'(ptr_q);
            arr_be    = '1;
            arr_wdata = '0;
        end else begin
            arr_we    = accept & bus.we & in_range;
            arr_addr  = bus.addr;
            arr_be    = bus.be;
            arr_wdata = bus.wdata;
        end
    end

    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk_i   (clk),
        .rst_i   (rst),
        .addr_i  (arr_addr),
        .we_i    (arr_we),
        .be_i    (arr_be),
        .wdata_i (arr_wdata),
        .re_i    (rd_acc),
        .rzero_i (~in_range),
        .rdata_o (arr_rdata)
    );

    assign bus.ready  = (state_q == READY);
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
    assign bus.rdata  = arr_rdata;
    assign state_o    = state_q;
    assign ptr_o      = ADDR_W'(ptr_q);
endmodule

// File: doc/data_ram.md
# data_ram

Parametrised single-port data memory for the multi-cycle processor, the successor of the current 8-bit/256-entry data RAM. It generalises data width and depth, adds per-byte write enables, a registered read port with a valid strobe, a request/ready handshake, and a hardware clear engine. After reset or a clear request, the clear engine zeroes the array one word per cycle. The block sits on the processor's memory stage, between the address/data registers and the memory-data register.

## Interface
- `DATA_W`, default 8: word width in bits; must be a multiple of 8.
- `ADDR_W`, default 8: address width.
- `DEPTH`, default 2**ADDR_W: number of words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_W.

Ports:
- `clk` in 1: single clock; all logic samples on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req` in 1: access request.
- `we` in 1: 1 = write, 0 = read; qualified by `req`.
- `addr` in ADDR_W: word address.
- `wdata` in DATA_W: write data.
- `be` in DATA_W/8: byte-lane write enables; bit i covers `wdata[8i+7:8i]`.
- `clr` in 1: request to re-zero the whole array.
- `ready` out 1: the block accepts requests in this cycle.
- `rvalid` out 1: one-cycle strobe; `rdata` holds a new read result.
- `rdata` out DATA_W: read data.
- `err` out 1: one-cycle strobe marking an out-of-range access.

## Operation
- FSM states:
  - SWEEP: clearing the array; `ready`=0.
  - READY: serving requests; `ready`=1.
- While `rst`=1 at an edge:
  - state goes to SWEEP and the sweep pointer goes to 0;
  - `rvalid`, `err` and `rdata` go to 0.
  - Array contents are not reset directly.
- SWEEP:
  - each edge writes all-zero to `mem[ptr]` and increments `ptr`;
  - the edge that writes `DEPTH-1` moves the FSM to READY.
- READY:
  - `clr`=1 → SWEEP with `ptr`=0.
  - `clr` has priority: any `req` in that same cycle is dropped (no write, no `rvalid`, no `err`).
- A request is accepted when `req & ready & ~clr` holds at an edge.
- Accepted write: each lane with `be[i]`=1 writes its byte; other lanes keep their value. `be`=0 is a legal no-op.
- Accepted read: `rdata` ← `mem[addr]` and `rvalid` ← 1.
- Out of range (`addr` ≥ DEPTH, possible only when DEPTH < 2**ADDR_W):
  - write: suppressed;
  - read: returns `rdata`=0 with `rvalid`=1;
  - either case: `err`=1 for one cycle.
- `rdata` holds its last value until the next accepted read or reset.
- `clr` while in SWEEP is ignored; the sweep does not restart.
- `rst` during a sweep restarts the sweep from address 0.

## Timing
- Reset values: `ready`=0, `rvalid`=0, `err`=0, `rdata`=0. The FSM starts in SWEEP with `ptr`=0.
- Clear latency:
  - The first edge with `rst`=0 clears address 0.
  - `ready` rises after the DEPTH-th such edge (256 cycles at the defaults).
  - The same latency applies after `clr`.
- Read latency is 1 cycle: for a read accepted at edge N, `rvalid` and `rdata` are valid from edge N until edge N+1.
- Back-to-back reads or writes are allowed every cycle.
- Writes are visible to a read accepted on the following edge.
- `ready` is a registered FSM output with no combinational path from any input.

## Structure
- Package `data_ram_pkg`:
  - FSM state typedef {SWEEP, READY};
  - `function clog2`;
  - localparam `NBYTES = DATA_W/8`.
- Sub-module `ram_array`: DEPTH×DATA_W storage with one write port (per-lane enable) and one registered read port. The sweep engine drives its write port with `be`=all-ones, data 0.
- The FSM, sweep pointer, handshake and range check live in `data_ram`.

## Test plan
- Reset then idle: assert `rst` 2 cycles, release → `ready`=0 for 256 edges and 1 after. A read of addresses 0, 128 and 255 returns 0 with `rvalid` pulsing once each.
- Byte-lane write (DATA_W=32): write `32'hAABBCCDD` to addr 5 with `be`=4'b1111, then write `32'h11223344` with `be`=4'b0101 → read addr 5 returns `32'hAA22CC44` one cycle after acceptance.
- Back-to-back: write addr 1=`8'h3C` at edge N, read addr 1 at edge N+1 → `rdata`=`8'h3C` with `rvalid`=1 after edge N+1.
- Clear priority: in READY, assert `clr` and a write (addr 7=`8'hFF`) in the same cycle → no write, `ready`=0 for DEPTH cycles, then a read of addr 7 returns 0.
- Reset mid-sweep: after 100 sweep cycles, pulse `rst` → `ptr` restarts at 0 and `ready` rises DEPTH edges after release.
- Out of range (DEPTH=200, ADDR_W=8): write addr 220, then read addr 220 → `err` pulses on both, read returns 0 with `rvalid`=1, and addresses 0–199 are unchanged.
